// File: rtl/dm_write_buffer.sv
// Data-memory responder for the CPU DM port: posted stores through a small FIFO with load forwarding.
// Build option DM_WBUF_EN enables the write buffer; without it stores write DM_data directly.
module dm_write_buffer #(
   parameter int unsigned bit_size = 32,
   parameter int unsigned mem_size = 16,
   parameter int unsigned DM_WORDS = 100,
   parameter int unsigned WB_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [mem_size-1:0]       DM_Address,
   input  logic                      DM_enable,
   input  logic [bit_size-1:0]       DM_Write_Data,
   output logic [bit_size-1:0]       DM_Read_Data,
   output logic [$clog2(WB_DEPTH):0] wb_count,
   output logic                      wb_empty,
   output logic                      wb_full
);
   localparam int unsigned AW = $clog2(DM_WORDS);

   logic [bit_size-1:0] DM_data [0:DM_WORDS-1];
   logic                w_in_range;
   logic [AW-1:0]       w_idx;

   assign w_in_range = (DM_Address < mem_size'(DM_WORDS));
   assign w_idx      = DM_Address[AW-1:0];

`ifdef DM_WBUF_EN
   localparam int unsigned PW = $clog2(WB_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [mem_size-1:0] r_addr [0:WB_DEPTH-1];
   logic [bit_size-1:0] r_data [0:WB_DEPTH-1];
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;
   logic                w_full;
   logic                w_drain;
   logic [mem_size-1:0] w_drain_addr;
   logic                w_fwd_hit;
   logic [bit_size-1:0] w_fwd_data;

   assign w_full       = (r_count == CW'(WB_DEPTH));
   // A full buffer retires its oldest entry even while a new store arrives
   assign w_drain      = (r_count != '0) && (!DM_enable || w_full);
   assign w_drain_addr = r_addr[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int unsigned i = 0; i < DM_WORDS; i++) DM_data[AW'(i)] <= '0;
      end else begin
         if (DM_enable) begin
            r_addr[r_wr_ptr] <= DM_Address;
            r_data[r_wr_ptr] <= DM_Write_Data;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         if (w_drain) begin
            if (w_drain_addr < mem_size'(DM_WORDS))
               DM_data[w_drain_addr[AW-1:0]] <= r_data[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (DM_enable && !w_drain)
            r_count <= r_count + 1'b1;
         else if (!DM_enable && w_drain)
            r_count <= r_count - 1'b1;
      end
   end

   // Scan oldest to newest so the last hit is the youngest matching store
   always_comb begin
      logic [PW-1:0] idx;
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      idx        = '0;
      for (int unsigned k = 0; k < WB_DEPTH; k++) begin
         idx = r_rd_ptr + PW'(k);
         if ((CW'(k) < r_count) && (r_addr[idx] == DM_Address)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_data[idx];
         end
      end
   end

   assign DM_Read_Data = w_fwd_hit  ? w_fwd_data :
                         w_in_range ? DM_data[w_idx] : '0;
   assign wb_count     = r_count;
   assign wb_empty     = (r_count == '0);
   assign wb_full      = w_full;
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DM_WORDS; i++) DM_data[AW'(i)] <= '0;
      end else if (DM_enable && w_in_range) begin
         DM_data[w_idx] <= DM_Write_Data;
      end
   end

   assign DM_Read_Data = w_in_range ? DM_data[w_idx] : '0;
   assign wb_count     = '0;
   assign wb_empty     = 1'b1;
   assign wb_full      = 1'b0;
`endif

endmodule
